msg_loader: RTL and testbench

- Upstream feeder for the 4-way interleaved message-schedule expander.
- Accepts 512-bit blocks as 16 x 32-bit words over a valid/ready stream. Collects four blocks (one per interleave slot) into a ping-pong buffer.
- Per batch, emits 64 interleaved words with send_o high, then holds send_o low for 192 cycles while the expander regenerates w16..w63. Total period is 256 cycles.
- Loads the next batch while the current one drains.

---
 rtl/sha256_pkg.sv | 22 ++
 rtl/msg_bank.sv | 26 ++
 rtl/msg_loader.sv | 129 ++++++++++++
 tb/tb_msg_loader.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// Shared constants, drain-state encoding and read-address helper for the
// message loader feeding the 4-way interleaved schedule expander.
package sha256_pkg;

    localparam int WORD_W      = 32;
    localparam int SLOTS       = 4;
    localparam int MSG_WORDS   = 16;
    localparam int ROUND_LEN   = 256;
    localparam int BATCH_WORDS = SLOTS * MSG_WORDS;

    typedef enum logic [1:0] {
        DRAIN_IDLE,
        DRAIN_SEND,
        DRAIN_WAIT
    } drain_state_t;

    // Interleaved read order: k -> (k%4)*16 + k/4, i.e. word k/4 of slot k%4.
    function automatic logic [5:0] rd_addr(input logic [5:0] k);
        return {k[1:0], k[5:2]};
    endfunction

endpackage

// File: rtl/msg_bank.sv
// Ping-pong storage for two 64-word batches: synchronous write, asynchronous
// read, no reset on the storage array.
module msg_bank
    import sha256_pkg::*;
(
    input  logic              clk_i,
    input  logic              we,
    input  logic              wr_bank,
    input  logic [5:0]        wr_addr,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              rd_bank,
    input  logic [5:0]        rd_idx,
    output logic [WORD_W-1:0] rd_data
);

    logic [WORD_W-1:0] mem [2][64];

    always_ff @(posedge clk_i) begin
        if (we) begin
            mem[wr_bank][wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_bank][rd_idx];

endmodule

// File: rtl/msg_loader.sv
// Collects four 16-word blocks per batch into a ping-pong buffer and streams
// them interleaved to the expander with a 256-cycle period per batch.
module msg_loader
    import sha256_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [WORD_W-1:0] in_data_i,
    output logic [WORD_W-1:0] data_o,
    output logic              send_o,
    output logic              batch_start_o,
    output logic [7:0]        round_o,
    output logic              busy_o
);

    localparam logic [7:0] LAST_K     = 8'(ROUND_LEN - 1);
    localparam logic [7:0] SEND_LAST  = 8'(BATCH_WORDS - 1);
    localparam logic [5:0] WPTR_LAST  = 6'(BATCH_WORDS - 1);

    logic [1:0]        full;
    logic              fill_bank;
    logic              drain_bank;
    logic [5:0]        wptr;
    drain_state_t      state;

    logic              hs;
    logic              fill_done;
    logic              release_bank;
    logic [1:0]        set_mask;
    logic [1:0]        clr_mask;
    logic [7:0]        next_k;
    logic [5:0]        rd_idx;
    logic [WORD_W-1:0] rd_data;

    assign in_ready_o   = !full[fill_bank];
    assign hs           = in_valid_i & in_ready_o;
    assign fill_done    = hs && (wptr == WPTR_LAST);
    assign release_bank = (state == DRAIN_SEND) && (round_o == SEND_LAST);
    assign set_mask     = fill_done    ? (2'b01 << fill_bank)  : 2'b00;
    assign clr_mask     = release_bank ? (2'b01 << drain_bank) : 2'b00;
    assign next_k       = round_o + 8'd1;
    // Outside SEND the next word presented is always word 0 of a fresh batch.
    assign rd_idx       = (state == DRAIN_SEND) ? rd_addr(next_k[5:0]) : 6'd0;

    msg_bank u_bank (
        .clk_i   (clk_i),
        .we      (hs),
        .wr_bank (fill_bank),
        .wr_addr (wptr),
        .wr_data (in_data_i),
        .rd_bank (drain_bank),
        .rd_idx  (rd_idx),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            full      <= 2'b00;
            fill_bank <= 1'b0;
            wptr      <= 6'd0;
        end else begin
            full <= (full | set_mask) & ~clr_mask;
            if (hs) begin
                wptr <= wptr + 6'd1;
                if (fill_done) begin
                    fill_bank <= ~fill_bank;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= DRAIN_IDLE;
            drain_bank    <= 1'b0;
            round_o       <= 8'd0;
            data_o        <= '0;
            send_o        <= 1'b0;
            batch_start_o <= 1'b0;
            busy_o        <= 1'b0;
        end else begin
            batch_start_o <= 1'b0;
            case (state)
                DRAIN_IDLE: begin
                    if (full[drain_bank]) begin
                        state         <= DRAIN_SEND;
                        round_o       <= 8'd0;
                        batch_start_o <= 1'b1;
                        busy_o        <= 1'b1;
                        send_o        <= 1'b1;
                        data_o        <= rd_data;
                    end
                end
                DRAIN_SEND: begin
                    round_o <= next_k;
                    if (release_bank) begin
                        state      <= DRAIN_WAIT;
                        drain_bank <= ~drain_bank;
                        send_o     <= 1'b0;
                        data_o     <= '0;
                    end else begin
                        data_o <= rd_data;
                    end
                end
                DRAIN_WAIT: begin
                    if (round_o == LAST_K) begin
                        if (full[drain_bank]) begin
                            state         <= DRAIN_SEND;
                            round_o       <= 8'd0;
                            batch_start_o <= 1'b1;
                            send_o        <= 1'b1;
                            data_o        <= rd_data;
                        end else begin
                            state   <= DRAIN_IDLE;
                            round_o <= 8'd0;
                            busy_o  <= 1'b0;
                        end
                    end else begin
                        round_o <= next_k;
                    end
                end
                default: state <= DRAIN_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_msg_loader.sv
// Self-checking bench for msg_loader: batch-level queue model compared every
// cycle, plus hand-computed expectations for ordering and timing.
module tb_msg_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = 32'd0;
    logic        in_ready;
    logic [31:0] data_o;
    logic        send_o;
    logic        batch_start_o;
    logic [7:0]  round_o;
    logic        busy_o;

    int errors = 0;
    int checks = 0;

    // Model: completed batches waiting/draining, partial fill, current batch.
    logic [31:0] fullw[$];
    logic [31:0] part[$];
    logic [31:0] cur[64];
    int          mk = -1;
    bit          mdl_on = 1'b0;
    bit          mdl_hs = 1'b0;
    int          cyc = 0;

    int          starts[$];
    logic [31:0] startdata[$];
    logic [31:0] sentq[$];
    logic [31:0] single_seq[$];
    int          hs_cyc[$];
    int          busy_cnt = 0;

    msg_loader dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .in_valid_i    (in_valid),
        .in_ready_o    (in_ready),
        .in_data_i     (in_data),
        .data_o        (data_o),
        .send_o        (send_o),
        .batch_start_o (batch_start_o),
        .round_o       (round_o),
        .busy_o        (busy_o)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin : model
        int nfull;
        nfull = fullw.size() / 64;
        cyc++;
        if (rst) begin
            fullw.delete();
            part.delete();
            mk     = -1;
            mdl_hs = 1'b0;
            mdl_on = 1'b1;
        end else begin
            mdl_hs = in_valid && (nfull < 2);
            if (mk < 0 || mk == 255) begin
                if (nfull > 0) begin
                    for (int i = 0; i < 64; i++) cur[i] = fullw[i];
                    mk = 0;
                end else begin
                    mk = -1;
                end
            end else if (mk == 63) begin
                mk = 64;
                for (int i = 0; i < 64; i++) void'(fullw.pop_front());
            end else begin
                mk++;
            end
            if (mdl_hs) begin
                part.push_back(in_data);
                hs_cyc.push_back(cyc);
                if (part.size() == 64) begin
                    foreach (part[i]) fullw.push_back(part[i]);
                    part.delete();
                end
            end
        end
    end

    always @(negedge clk) begin : compare
        bit          es;
        logic [31:0] ed;
        if (mdl_on) begin
            es = (mk >= 0 && mk < 64);
            ed = es ? cur[(mk % 4) * 16 + mk / 4] : 32'd0;
            checkOutput("send_o", 32'(send_o), 32'(es));
            checkOutput("data_o", data_o, ed);
            checkOutput("round_o", 32'(round_o), (mk < 0) ? 32'd0 : 32'(mk));
            checkOutput("busy_o", 32'(busy_o), 32'(mk >= 0));
            checkOutput("batch_start_o", 32'(batch_start_o), 32'(mk == 0));
            checkOutput("in_ready_o", 32'(in_ready), 32'((fullw.size() / 64) < 2));
        end
    end

    always @(negedge clk) begin : monitor
        if (mdl_on && !rst) begin
            if (batch_start_o === 1'b1) begin
                starts.push_back(cyc);
                startdata.push_back(data_o);
            end
            if (send_o === 1'b1) sentq.push_back(data_o);
            if (busy_o === 1'b1) busy_cnt++;
        end
    end

    task automatic applyStimulus(input int count, input logic [31:0] base, input bit gappy);
        int n = 0;
        int budget = 0;
        while (n < count && budget < 3000) begin
            @(negedge clk);
            in_valid = gappy ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data  = base + 32'(n);
            @(posedge clk);
            #1;
            if (mdl_hs) n++;
            budget++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("feed_count", 32'(n), 32'(count));
    endtask

    task automatic waitIdle();
        int b = 0;
        while (!(mk < 0 && fullw.size() == 0 && part.size() == 0) && b < 3000) begin
            @(negedge clk);
            b++;
        end
        checkOutput("idle_reached", 32'(b < 3000), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    task automatic clearRecords();
        starts.delete();
        startdata.delete();
        sentq.delete();
        hs_cyc.delete();
        busy_cnt = 0;
    endtask

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin : main
        int b;
        int bad;

        // Reset state
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("rst_send", 32'(send_o), 32'd0);
        checkOutput("rst_data", data_o, 32'd0);
        checkOutput("rst_round", 32'(round_o), 32'd0);
        checkOutput("rst_busy", 32'(busy_o), 32'd0);
        checkOutput("rst_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;

        // Single batch, data = n
        clearRecords();
        applyStimulus(64, 32'd0, 1'b0);
        waitIdle();
        checkOutput("single_len", 32'(sentq.size()), 32'd64);
        checkOutput("single_starts", 32'(starts.size()), 32'd1);
        checkOutput("single_busy_cycles", 32'(busy_cnt), 32'd256);
        if (sentq.size() == 64 && starts.size() == 1) begin
            checkOutput("single_k0", sentq[0], 32'd0);
            checkOutput("single_k1", sentq[1], 32'd16);
            checkOutput("single_k3", sentq[3], 32'd48);
            checkOutput("single_k4", sentq[4], 32'd1);
            checkOutput("single_k62", sentq[62], 32'd47);
            checkOutput("single_k63", sentq[63], 32'd63);
            checkOutput("start_latency", 32'(starts[0] - hs_cyc[63]), 32'd1);
        end
        single_seq = sentq;

        // Back-to-back batches plus a third batch under backpressure
        clearRecords();
        applyStimulus(192, 32'd0, 1'b0);
        waitIdle();
        checkOutput("b2b_starts", 32'(starts.size()), 32'd3);
        checkOutput("b2b_len", 32'(sentq.size()), 32'd192);
        if (starts.size() == 3 && hs_cyc.size() == 192) begin
            checkOutput("b2b_gap1", 32'(starts[1] - starts[0]), 32'd256);
            checkOutput("b2b_gap2", 32'(starts[2] - starts[1]), 32'd256);
            checkOutput("b2b_first0", startdata[0], 32'd0);
            checkOutput("b2b_first1", startdata[1], 32'd64);
            checkOutput("b2b_first2", startdata[2], 32'd128);
            checkOutput("bp_first_accept", 32'(hs_cyc[128] - starts[0]), 32'd65);
        end

        // Reset in the middle of SEND at k=30
        clearRecords();
        applyStimulus(64, 32'h100, 1'b0);
        b = 0;
        while (mk != 30 && b < 1000) begin
            @(negedge clk);
            b++;
        end
        checkOutput("reached_k30", 32'(round_o), 32'd30);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midrst_send", 32'(send_o), 32'd0);
        checkOutput("midrst_data", data_o, 32'd0);
        checkOutput("midrst_round", 32'(round_o), 32'd0);
        checkOutput("midrst_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;
        clearRecords();
        applyStimulus(64, 32'h200, 1'b0);
        waitIdle();
        checkOutput("reload_len", 32'(sentq.size()), 32'd64);
        if (sentq.size() == 64) begin
            checkOutput("reload_k0", sentq[0], 32'h200);
            checkOutput("reload_k1", sentq[1], 32'h210);
            checkOutput("reload_k63", sentq[63], 32'h23F);
        end

        // Gappy input must give the same ordering as the single batch
        clearRecords();
        applyStimulus(64, 32'hA500_0000, 1'b1);
        waitIdle();
        checkOutput("gappy_len", 32'(sentq.size()), 32'd64);
        if (sentq.size() == 64 && single_seq.size() == 64) begin
            bad = 0;
            for (int i = 0; i < 64; i++) begin
                if ((sentq[i] - 32'hA500_0000) !== single_seq[i]) bad++;
            end
            checkOutput("gappy_order", 32'(bad), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
